collision_score_unit: RTL and testbench

- Consumes the x/y centre positions of two pipe instances and the bird's vertical position.
- Once per video frame it decides bird–pipe or bird–boundary collision and counts pipes passed.
- Runs the game-state FSM (IDLE/PLAY/DEAD) whose `game_run` output gates pipe and bird motion upstream.
- Score drives the on-screen score renderer downstream.

---
 rtl/flappy_pkg.sv | 18 +
 rtl/pipe_hit_check.sv | 49 ++++
 rtl/collision_score_unit.sv | 126 ++++++++++++
 tb/tb_collision_score_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared game definitions: the state encoding, the screen limits and the pipe geometry
// used by the collision logic and by the pipe renderer.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam int TOP_LIMIT   = 35;
  localparam int BOT_LIMIT   = 515;
  localparam int X_MIN       = 94;
  localparam int X_MAX       = 850;
  localparam int GAP_HALF    = 50;
  localparam int PIPE_HALF_W = 50;

endpackage

// File: rtl/pipe_hit_check.sv
// Per-pipe collision and pass detection. It keeps the pipe x position seen on the
// previous frame tick, so a pass is a move from right of the bird to at or left of it.
module pipe_hit_check
  import flappy_pkg::*;
#(
  parameter int BIRD_X    = 200,
  parameter int BIRD_HALF = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic [10:0] i_bird_y,
  input  logic [11:0] i_pipe_x,
  input  logic [10:0] i_pipe_y,
  output logic        o_hit,
  output logic        o_pass
);

  localparam logic signed [12:0] C_BIRD_X = 13'(BIRD_X);
  localparam logic signed [12:0] C_BIRD_H = 13'(BIRD_HALF);
  localparam logic signed [12:0] C_GAP_H  = 13'(GAP_HALF);
  localparam logic signed [12:0] C_REACH  = 13'(PIPE_HALF_W + BIRD_HALF);

  logic [11:0]        r_prev_x;
  logic signed [12:0] w_px, w_py, w_by, w_dx, w_adx;
  logic               w_on_screen, w_in_x, w_out_gap;

  // Widened by a zero sign bit so differences can go negative without wrapping.
  assign w_px  = $signed({1'b0, i_pipe_x});
  assign w_py  = $signed({2'b00, i_pipe_y});
  assign w_by  = $signed({2'b00, i_bird_y});
  assign w_dx  = w_px - C_BIRD_X;
  assign w_adx = w_dx[12] ? -w_dx : w_dx;

  assign w_on_screen = (i_pipe_x >= 12'(X_MIN)) && (i_pipe_x <= 12'(X_MAX));
  assign w_in_x      = w_on_screen && (w_adx <= C_REACH);
  assign w_out_gap   = ((w_by - C_BIRD_H) < (w_py - C_GAP_H)) ||
                       ((w_by + C_BIRD_H) > (w_py + C_GAP_H));

  assign o_hit  = w_in_x && w_out_gap;
  assign o_pass = (r_prev_x > 12'(BIRD_X)) && (i_pipe_x <= 12'(BIRD_X));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_prev_x <= '0;
    else if (i_frame_tick) r_prev_x <= i_pipe_x;
  end

endmodule

// File: rtl/collision_score_unit.sv
// Per-frame collision, scoring and IDLE/PLAY/DEAD game-state control for the bird.
// Define COLLISION_HIGH_SCORE_EN to keep a best-score register; otherwise high_score is 0.
module collision_score_unit
  import flappy_pkg::*;
#(
  parameter int BIRD_X      = 200,
  parameter int BIRD_HALF   = 10,
  parameter int HOLD_FRAMES = 60,
  parameter int SCORE_MAX   = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        up,
  input  logic [10:0] bird_y,
  input  logic [11:0] pipe0_x,
  input  logic [10:0] pipe0_y,
  input  logic [11:0] pipe1_x,
  input  logic [10:0] pipe1_y,
  output logic        game_run,
  output logic        dead,
  output logic [9:0]  score,
  output logic [9:0]  high_score
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  game_state_t       r_state, w_state_next;
  logic              r_up_meta, r_up_sync, r_up_prev, r_up_pulse;
  logic [HOLD_W-1:0] r_hold;
  logic [9:0]        r_score;
  logic              w_hit0, w_hit1, w_pass0, w_pass1, w_bound_hit, w_hit;
  logic              w_to_play, w_to_dead;
  logic [10:0]       w_score_sum;
  logic [9:0]        w_score_sat;

  pipe_hit_check #(.BIRD_X(BIRD_X), .BIRD_HALF(BIRD_HALF)) u_pipe0 (
    .clk(clk), .rst(rst), .i_frame_tick(frame_tick), .i_bird_y(bird_y),
    .i_pipe_x(pipe0_x), .i_pipe_y(pipe0_y), .o_hit(w_hit0), .o_pass(w_pass0)
  );

  pipe_hit_check #(.BIRD_X(BIRD_X), .BIRD_HALF(BIRD_HALF)) u_pipe1 (
    .clk(clk), .rst(rst), .i_frame_tick(frame_tick), .i_bird_y(bird_y),
    .i_pipe_x(pipe1_x), .i_pipe_y(pipe1_y), .o_hit(w_hit1), .o_pass(w_pass1)
  );

  assign w_bound_hit = ({2'b00, bird_y} < 13'(TOP_LIMIT + BIRD_HALF)) ||
                       ({2'b00, bird_y} + 13'(BIRD_HALF) > 13'(BOT_LIMIT));
  assign w_hit       = w_hit0 || w_hit1 || w_bound_hit;

  assign w_score_sum = {1'b0, r_score} + 11'(w_pass0) + 11'(w_pass1);
  assign w_score_sat = (w_score_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : w_score_sum[9:0];

  // Two-flop synchroniser, then a registered rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up_meta  <= 1'b0;
      r_up_sync  <= 1'b0;
      r_up_prev  <= 1'b0;
      r_up_pulse <= 1'b0;
    end else begin
      r_up_meta  <= up;
      r_up_sync  <= r_up_meta;
      r_up_prev  <= r_up_sync;
      r_up_pulse <= r_up_sync && !r_up_prev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (r_up_pulse)                        w_state_next = PLAY;
      PLAY: if (frame_tick && w_hit)               w_state_next = DEAD;
      DEAD: if (frame_tick && r_hold <= HOLD_W'(1)) w_state_next = IDLE;
      default:                                     w_state_next = IDLE;
    endcase
  end

  always_comb begin
    game_run = (r_state == PLAY);
    dead     = (r_state == DEAD);
  end

  assign w_to_play = (r_state == IDLE) && (w_state_next == PLAY);
  assign w_to_dead = (r_state == PLAY) && (w_state_next == DEAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
      r_hold  <= '0;
    end else begin
      if (w_to_play)
        r_score <= '0;
      else if (r_state == PLAY && frame_tick && !w_hit)
        r_score <= w_score_sat;

      if (w_to_dead)
        r_hold <= HOLD_W'(HOLD_FRAMES);
      else if (r_state == DEAD && frame_tick && r_hold != '0)
        r_hold <= r_hold - HOLD_W'(1);
    end
  end

  assign score = r_score;

`ifdef COLLISION_HIGH_SCORE_EN
  logic [9:0] r_high;

  // Score is frozen on the dying tick, so the value compared is the final game score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_high <= '0;
    else if (w_to_dead && r_score > r_high) r_high <= r_score;
  end

  assign high_score = r_high;
`else
  assign high_score = '0;
`endif

endmodule

// File: tb/tb_collision_score_unit.sv
// Table-driven, scoreboard-checked bench for collision_score_unit; the high-score
// expectations follow COLLISION_HIGH_SCORE_EN when the bench is built with it.
module tb_collision_score_unit;

`ifdef COLLISION_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  typedef struct {
    logic [10:0] by;
    logic [11:0] p0x;
    logic [10:0] p0y;
    logic [11:0] p1x;
    logic [10:0] p1y;
    logic        run;
    logic        dead;
    logic [9:0]  score;
    logic [9:0]  high;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        up = 1'b0;
  logic [10:0] bird_y = 11'd250;
  logic [11:0] pipe0_x = 12'd1000;
  logic [10:0] pipe0_y = 11'd250;
  logic [11:0] pipe1_x = 12'd1000;
  logic [10:0] pipe1_y = 11'd250;
  logic        game_run, dead;
  logic [9:0]  score, high_score;

  int   n_total = 0;
  int   n_pass  = 0;
  vec_t exp_q[$];
  vec_t vecs[17];

  collision_score_unit dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .up(up), .bird_y(bird_y),
    .pipe0_x(pipe0_x), .pipe0_y(pipe0_y), .pipe1_x(pipe1_x), .pipe1_y(pipe1_y),
    .game_run(game_run), .dead(dead), .score(score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  function automatic int hs(int v);
    return HS_EN ? v : 0;
  endfunction

  function automatic vec_t mk(int by, int p0x, int p0y, int p1x, int p1y,
                              int run, int dd, int sc, int hi);
    vec_t v;
    v.by = 11'(by); v.p0x = 12'(p0x); v.p0y = 11'(p0y);
    v.p1x = 12'(p1x); v.p1y = 11'(p1y);
    v.run = 1'(run); v.dead = 1'(dd); v.score = 10'(sc); v.high = 10'(hi);
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drives one frame tick and compares against the expectation queued with it.
  task automatic apply(string tag, vec_t v);
    vec_t e;
    @(negedge clk);
    bird_y = v.by; pipe0_x = v.p0x; pipe0_y = v.p0y; pipe1_x = v.p1x; pipe1_y = v.p1y;
    frame_tick = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    frame_tick = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".game_run"}, int'(game_run), int'(e.run));
    check({tag, ".dead"}, int'(dead), int'(e.dead));
    check({tag, ".score"}, int'(score), int'(e.score));
    check({tag, ".high_score"}, int'(high_score), int'(e.high));
  endtask

  task automatic flap_start(string tag);
    int n;
    n = 0;
    @(negedge clk);
    up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (game_run) begin
        n = i;
        break;
      end
    end
    check({tag, ".latency"}, n, 4);
    check({tag, ".score_cleared"}, int'(score), 0);
    check({tag, ".dead"}, int'(dead), 0);
    @(negedge clk);
    up = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic dead_hold(string tag, int sc, int hi, bit do_flap);
    for (int t = 1; t <= 60; t++) begin
      if (do_flap && t == 30) begin
        @(negedge clk);
        up = 1'b1;
        repeat (6) @(negedge clk);
        up = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, ".flap_ignored"}, int'(dead), 1);
      end
      apply(tag, mk(250, 1000, 250, 1000, 250, 0, (t < 60) ? 1 : 0, sc, hi));
    end
    repeat (6) @(negedge clk);
    check({tag, ".stays_idle"}, int'(game_run), 0);
  endtask

  initial begin
    int exp_sc;

    // Game 1: gap edges, x reach, single and double passes, wrap, hit with pass.
    vecs[0]  = mk(250, 202, 250, 1000, 250, 1, 0, 0, 0);
    vecs[1]  = mk(250, 200, 250, 1000, 250, 1, 0, 1, 0);
    vecs[2]  = mk(250, 261, 400, 1000, 250, 1, 0, 1, 0);
    vecs[3]  = mk(210, 230, 250, 1000, 250, 1, 0, 1, 0);
    vecs[4]  = mk(290, 210, 250, 201, 250, 1, 0, 1, 0);
    vecs[5]  = mk(250, 195, 250, 199, 250, 1, 0, 3, 0);
    vecs[6]  = mk(250, 40, 250, 1000, 250, 1, 0, 3, 0);
    vecs[7]  = mk(250, 1240, 250, 1000, 250, 1, 0, 3, 0);
    vecs[8]  = mk(250, 201, 250, 201, 250, 1, 0, 3, 0);
    vecs[9]  = mk(250, 200, 250, 200, 250, 1, 0, 5, 0);
    vecs[10] = mk(250, 201, 250, 1000, 250, 1, 0, 5, 0);
    vecs[11] = mk(195, 200, 250, 1000, 250, 0, 1, 5, hs(5));
    // Game 2: reaches 3, dies on the top boundary.
    vecs[12] = mk(250, 201, 250, 201, 250, 1, 0, 0, hs(5));
    vecs[13] = mk(250, 200, 250, 200, 250, 1, 0, 2, hs(5));
    vecs[14] = mk(250, 201, 250, 1000, 250, 1, 0, 2, hs(5));
    vecs[15] = mk(250, 200, 250, 1000, 250, 1, 0, 3, hs(5));
    vecs[16] = mk(20, 1000, 250, 1000, 250, 0, 1, 3, hs(5));

    repeat (3) @(negedge clk);
    check("reset.game_run", int'(game_run), 0);
    check("reset.dead", int'(dead), 0);
    check("reset.score", int'(score), 0);
    check("reset.high_score", int'(high_score), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle.no_start", int'(game_run), 0);

    flap_start("g1.flap");
    for (int i = 0; i <= 11; i++) apply($sformatf("g1.v%0d", i), vecs[i]);
    dead_hold("g1.hold", 5, hs(5), 1'b1);

    flap_start("g2.flap");
    for (int i = 12; i <= 16; i++) apply($sformatf("g2.v%0d", i), vecs[i]);
    dead_hold("g2.hold", 3, hs(5), 1'b0);

    // Game 3: double passes up to and past the saturation value.
    flap_start("g3.flap");
    exp_sc = 0;
    apply("g3.arm", mk(250, 201, 250, 201, 250, 1, 0, exp_sc, hs(5)));
    for (int k = 0; k < 505; k++) begin
      exp_sc = (exp_sc + 2 > 999) ? 999 : exp_sc + 2;
      apply("g3.pass", mk(250, 200, 250, 200, 250, 1, 0, exp_sc, hs(5)));
      apply("g3.rearm", mk(250, 201, 250, 201, 250, 1, 0, exp_sc, hs(5)));
    end
    check("g3.saturated", int'(score), 999);

    // Asynchronous reset in the middle of play clears outputs before any edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.game_run", int'(game_run), 0);
    check("arst.dead", int'(dead), 0);
    check("arst.score", int'(score), 0);
    check("arst.high_score", int'(high_score), 0);
    @(negedge clk);
    rst = 1'b0;

    // Game 4: boundary edges at top and bottom.
    flap_start("g4.flap");
    apply("g4.top_edge", mk(45, 1000, 250, 1000, 250, 1, 0, 0, 0));
    apply("g4.bot_edge", mk(505, 1000, 250, 1000, 250, 1, 0, 0, 0));
    apply("g4.bot_hit", mk(510, 1000, 250, 1000, 250, 0, 1, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
